// File: rtl/pipe_hazard_ctrl.sv
// Hazard control beside ID: tracks destination/control fields of the instructions in EX and MEM,
// raises load-use stalls and taken-branch flushes, and registers EX forwarding selects.
module pipe_hazard_ctrl #(
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_Rn,
    input  logic [4:0]       id_Rm,
    input  logic             id_useRn,
    input  logic             id_useRm,
    input  logic [4:0]       id_Rd,
    input  logic             id_RegWrite,
    input  logic             id_MemToReg,
    input  logic             id_flagWrite,
    input  logic             id_isCondBr,
    input  logic             ex_brTaken,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwdA_out,
    output logic [1:0]       fwdB_out,
    output logic             flagFwd_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned      REG_W     = 5;
    localparam logic [REG_W-1:0] ZR        = REG_W'(ZERO_REG);
    localparam logic [1:0]       FWD_RF    = 2'b00;
    localparam logic [1:0]       FWD_EXMEM = 2'b01;
    localparam logic [1:0]       FWD_MEMWB = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {
        ST_RUN,
        ST_STALL
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Shadows only go as far as MEM: the regfile writes before it reads, so WB needs no forwarding.
    logic [REG_W-1:0] r_ex_rd;
    logic             r_ex_regwrite;
    logic             r_ex_memtoreg;
    logic             r_ex_flagwrite;
    logic [REG_W-1:0] r_mem_rd;
    logic             r_mem_regwrite;

    logic             w_lu;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    function automatic logic f_match(input logic use_r, input logic [REG_W-1:0] r,
                                     input logic s_rw, input logic [REG_W-1:0] s_rd);
        return use_r && s_rw && (s_rd == r) && (r != ZR);
    endfunction

    assign w_lu = r_ex_memtoreg &&
                  (f_match(id_useRn, id_Rn, r_ex_regwrite, r_ex_rd) ||
                   f_match(id_useRm, id_Rm, r_ex_regwrite, r_ex_rd));

    // Next-state and pipeline control; a taken branch overrides a load-use stall.
    always_comb begin
        w_state_nxt = r_state;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_RUN: begin
                    if (ex_brTaken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (w_lu) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                        w_state_nxt = ST_STALL;
                    end
                end
                ST_STALL: begin
                    w_state_nxt = ST_RUN;
                    if (ex_brTaken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_comb begin
        w_fwd_a = FWD_RF;
        w_fwd_b = FWD_RF;
        if (!idex_bubble) begin
            if (f_match(id_useRn, id_Rn, r_ex_regwrite, r_ex_rd))
                w_fwd_a = FWD_EXMEM;
            else if (f_match(id_useRn, id_Rn, r_mem_regwrite, r_mem_rd))
                w_fwd_a = FWD_MEMWB;
            if (f_match(id_useRm, id_Rm, r_ex_regwrite, r_ex_rd))
                w_fwd_b = FWD_EXMEM;
            else if (f_match(id_useRm, id_Rm, r_mem_regwrite, r_mem_rd))
                w_fwd_b = FWD_MEMWB;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_RUN;
            r_ex_rd        <= '0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memtoreg  <= 1'b0;
            r_ex_flagwrite <= 1'b0;
            r_mem_rd       <= '0;
            r_mem_regwrite <= 1'b0;
            fwdA_out       <= FWD_RF;
            fwdB_out       <= FWD_RF;
            flagFwd_out    <= 1'b0;
            stall_cnt      <= '0;
            flush_cnt      <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_ex_rd        <= idex_bubble ? '0 : id_Rd;
            r_ex_regwrite  <= idex_bubble ? 1'b0 : id_RegWrite;
            r_ex_memtoreg  <= idex_bubble ? 1'b0 : id_MemToReg;
            r_ex_flagwrite <= idex_bubble ? 1'b0 : id_flagWrite;
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;
            fwdA_out       <= w_fwd_a;
            fwdB_out       <= w_fwd_b;
            flagFwd_out    <= id_isCondBr && r_ex_flagwrite && !idex_bubble;
            if (pc_hold && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed instruction sequences plus random traffic,
// every cycle compared against a queue-of-instructions reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_Rn, id_Rm, id_Rd;
    logic             id_useRn, id_useRm, id_RegWrite, id_MemToReg, id_flagWrite, id_isCondBr;
    logic             ex_brTaken;
    logic             pc_hold, ifid_hold, ifid_flush, idex_bubble, flagFwd_out;
    logic [1:0]       fwdA_out, fwdB_out;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.ZERO_REG(31), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_Rn(id_Rn), .id_Rm(id_Rm), .id_useRn(id_useRn), .id_useRm(id_useRm),
        .id_Rd(id_Rd), .id_RegWrite(id_RegWrite), .id_MemToReg(id_MemToReg),
        .id_flagWrite(id_flagWrite), .id_isCondBr(id_isCondBr), .ex_brTaken(ex_brTaken),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .fwdA_out(fwdA_out), .fwdB_out(fwdB_out),
        .flagFwd_out(flagFwd_out), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic [4:0] rd, rn, rm;
        logic       rw, m2r, fw, cbr, use_rn, use_rm, br, rst;
    } stim_t;

    typedef struct {
        logic [4:0] rd;
        logic       rw, m2r, fw;
    } instr_t;

    instr_t     pipe_q[$];   // [0] = instruction in EX, [1] = instruction in MEM
    logic [1:0] m_fwd_a, m_fwd_b;
    logic       m_flag;
    int         m_stall, m_flush;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic stim_t op(input logic [4:0] rd, rn, rm,
                                 input logic rw, m2r, fw, cbr, use_rn, use_rm);
        stim_t s;
        s.rd = rd; s.rn = rn; s.rm = rm;
        s.rw = rw; s.m2r = m2r; s.fw = fw; s.cbr = cbr;
        s.use_rn = use_rn; s.use_rm = use_rm;
        s.br = 1'b0; s.rst = 1'b0;
        return s;
    endfunction

    function automatic logic hits(input logic use_r, input logic [4:0] r, input instr_t i);
        return use_r && i.rw && (i.rd == r) && (r != 5'd31);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic use_r, input logic [4:0] r);
        if (hits(use_r, r, pipe_q[0])) return 2'b01;
        if (hits(use_r, r, pipe_q[1])) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        instr_t nop;
        nop = '{rd: 5'd0, rw: 1'b0, m2r: 1'b0, fw: 1'b0};
        pipe_q = {nop, nop};
        m_fwd_a = 2'b00; m_fwd_b = 2'b00; m_flag = 1'b0;
        m_stall = 0; m_flush = 0;
    endtask

    // One clock: drive after negedge, compare, then advance the model across the posedge.
    task automatic run_cycle(input stim_t s);
        logic   lu, e_stall, e_flush, e_bubble;
        instr_t nw;
        @(negedge clk);
        reset = s.rst; ex_brTaken = s.br;
        id_Rd = s.rd; id_Rn = s.rn; id_Rm = s.rm;
        id_RegWrite = s.rw; id_MemToReg = s.m2r; id_flagWrite = s.fw; id_isCondBr = s.cbr;
        id_useRn = s.use_rn; id_useRm = s.use_rm;
        #1;
        lu       = pipe_q[0].m2r && (hits(s.use_rn, s.rn, pipe_q[0]) || hits(s.use_rm, s.rm, pipe_q[0]));
        e_flush  = !s.rst && s.br;
        e_stall  = !s.rst && !s.br && lu;
        e_bubble = e_flush || e_stall;
        check_eq("pc_hold",     32'(pc_hold),     32'(e_stall));
        check_eq("ifid_hold",   32'(ifid_hold),   32'(e_stall));
        check_eq("ifid_flush",  32'(ifid_flush),  32'(e_flush));
        check_eq("idex_bubble", 32'(idex_bubble), 32'(e_bubble));
        check_eq("fwdA",        32'(fwdA_out),    32'(m_fwd_a));
        check_eq("fwdB",        32'(fwdB_out),    32'(m_fwd_b));
        check_eq("flagFwd",     32'(flagFwd_out), 32'(m_flag));
        check_eq("stall_cnt",   32'(stall_cnt),   32'(m_stall));
        check_eq("flush_cnt",   32'(flush_cnt),   32'(m_flush));
        if (s.rst) begin
            model_reset();
        end else begin
            m_fwd_a = e_bubble ? 2'b00 : fwd_sel(s.use_rn, s.rn);
            m_fwd_b = e_bubble ? 2'b00 : fwd_sel(s.use_rm, s.rm);
            m_flag  = s.cbr && pipe_q[0].fw && !e_bubble;
            if (e_stall && m_stall < CNT_MAX) m_stall++;
            if (e_flush && m_flush < CNT_MAX) m_flush++;
            nw = e_bubble ? '{rd: 5'd0, rw: 1'b0, m2r: 1'b0, fw: 1'b0}
                          : '{rd: s.rd, rw: s.rw, m2r: s.m2r, fw: s.fw};
            pipe_q.push_front(nw);
            void'(pipe_q.pop_back());
        end
        @(posedge clk);
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd1;
            1:       return 5'd2;
            2:       return 5'd3;
            default: return 5'd31;
        endcase
    endfunction

    stim_t s_rst, s_nop, s_add1, s_sub, s_ld1, s_use1, s_ld31, s_use31, s_subs, s_bcond, s_self, s;

    initial begin
        s_nop   = op(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        s_rst   = s_nop; s_rst.rst = 1'b1;
        s_add1  = op(5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 1, 1);   // ADD X1,X2,X3
        s_sub   = op(5'd2, 5'd1, 5'd3, 1, 0, 0, 0, 1, 1);   // SUB X2,X1,X3
        s_ld1   = op(5'd1, 5'd5, 5'd0, 1, 1, 0, 0, 1, 0);   // LDUR X1,[X5]
        s_use1  = op(5'd2, 5'd1, 5'd4, 1, 0, 0, 0, 1, 1);   // ADD X2,X1,X4
        s_ld31  = op(5'd31, 5'd5, 5'd0, 1, 1, 0, 0, 1, 0);  // LDUR X31,[X5]
        s_use31 = op(5'd2, 5'd31, 5'd31, 1, 0, 0, 0, 1, 1); // ADD X2,X31,X31
        s_subs  = op(5'd9, 5'd2, 5'd3, 1, 0, 1, 0, 1, 1);   // SUBS X9,X2,X3
        s_bcond = op(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);   // B.cond
        s_self  = op(5'd1, 5'd1, 5'd0, 1, 1, 0, 0, 1, 0);   // LDUR X1,[X1]

        reset = 1'b1; ex_brTaken = 1'b0;
        id_Rd = '0; id_Rn = '0; id_Rm = '0;
        id_RegWrite = 0; id_MemToReg = 0; id_flagWrite = 0; id_isCondBr = 0;
        id_useRn = 0; id_useRm = 0;
        repeat (2) @(posedge clk);
        model_reset();

        run_cycle(s_rst);
        run_cycle(s_add1); run_cycle(s_sub);
        #1 check_eq("add_sub_fwdA_exmem", 32'(fwdA_out), 32'd1);

        run_cycle(s_rst);
        run_cycle(s_add1); run_cycle(s_nop); run_cycle(s_sub);
        #1 check_eq("add_nop_sub_fwdA_memwb", 32'(fwdA_out), 32'd2);

        run_cycle(s_rst);
        run_cycle(s_ld1); run_cycle(s_use1);
        #1 check_eq("lu_one_cycle_hold", 32'(pc_hold), 32'd0);
        run_cycle(s_use1);
        #1 check_eq("lu_fwdA_after_stall", 32'(fwdA_out), 32'd2);
        check_eq("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        run_cycle(s_rst);
        run_cycle(s_ld31); run_cycle(s_use31);
        #1 check_eq("x31_no_stall", 32'(stall_cnt), 32'd0);
        check_eq("x31_fwdA", 32'(fwdA_out), 32'd0);

        run_cycle(s_rst);
        run_cycle(s_ld1); s = s_use1; s.br = 1'b1; run_cycle(s);
        #1 check_eq("br_lu_stall_cnt", 32'(stall_cnt), 32'd0);
        check_eq("br_lu_flush_cnt", 32'(flush_cnt), 32'd1);

        run_cycle(s_rst);
        run_cycle(s_subs); run_cycle(s_bcond);
        #1 check_eq("subs_bcond_flagfwd", 32'(flagFwd_out), 32'd1);
        run_cycle(s_rst);
        run_cycle(s_subs); run_cycle(s_nop); run_cycle(s_bcond);
        #1 check_eq("subs_nop_bcond_flagfwd", 32'(flagFwd_out), 32'd0);

        run_cycle(s_rst);
        run_cycle(s_ld1); run_cycle(s_use1);
        s = s_use1; s.rst = 1'b1; run_cycle(s);
        s = s_use1; run_cycle(s);
        #1 check_eq("rst_mid_stall_fwdA", 32'(fwdA_out), 32'd0);
        check_eq("rst_mid_stall_cnt", 32'(stall_cnt), 32'd0);

        run_cycle(s_rst);
        repeat (2 * ((1 << CNT_W) + 3)) run_cycle(s_self);
        #1 check_eq("stall_cnt_saturate", 32'(stall_cnt), 32'(CNT_MAX));

        for (int i = 0; i < 600; i++) begin
            s.rd = pick_reg(); s.rn = pick_reg(); s.rm = pick_reg();
            s.rw = 1'($urandom_range(0, 1)); s.m2r = 1'($urandom_range(0, 1));
            s.fw = 1'($urandom_range(0, 1)); s.cbr = 1'($urandom_range(0, 1));
            s.use_rn = 1'($urandom_range(0, 1)); s.use_rm = 1'($urandom_range(0, 1));
            s.br  = ($urandom_range(0, 7) == 0);
            s.rst = ($urandom_range(0, 49) == 0);
            run_cycle(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
